// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32 control decoder followed by STAGES pipeline control registers.
// Stage 0 is EX, stage 1 is MEM, stage 2 is WB. The datapath taps every stage.
// Supports an external stall, a branch flush and load-use bubble insertion.
module ctrl_pipe #(
    parameter int STAGES = 3,
    parameter int RA_W   = 5,
    parameter int CW     = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             opcode,
    input  logic [RA_W-1:0]        rd,
    input  logic [RA_W-1:0]        rs1,
    input  logic [RA_W-1:0]        rs2,
    input  logic                   stall,
    input  logic                   flush,
    output logic [STAGES*CW-1:0]   ctrl_o,
    output logic [STAGES-1:0]      valid_o,
    output logic [STAGES*RA_W-1:0] rd_o,
    output logic                   load_use
);

    // Bundle bit positions, MSB to LSB.
    localparam int B_ILLEGAL  = 11;
    localparam int B_LUI      = 10;
    localparam int B_AUIPC    = 9;
    localparam int B_JUMP     = 8;
    localparam int B_REGWRITE = 7;
    localparam int B_ALUSRC   = 6;
    localparam int B_MEMWRITE = 5;
    localparam int B_ALUOP_HI = 4;
    localparam int B_ALUOP_LO = 3;
    localparam int B_MEMTOREG = 2;
    localparam int B_MEMREAD  = 1;
    localparam int B_BRANCH   = 0;

    // opcode = instr[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;

    logic [CW-1:0]   dec;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            bubble;

    logic [CW-1:0]   ctrl_q  [STAGES];
    logic [RA_W-1:0] rd_q    [STAGES];
    logic [STAGES-1:0] valid_q;

    // Decode the incoming opcode into the control bundle and its source-register usage.
    always_comb begin
        dec      = '0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                dec[B_MEMREAD]  = 1'b1;
                dec[B_MEMTOREG] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
                dec[B_REGWRITE] = 1'b1;
            end
            OPC_STORE: begin
                dec[B_MEMWRITE] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
                uses_rs2        = 1'b1;
            end
            OPC_BRANCH: begin
                dec[B_BRANCH]   = 1'b1;
                dec[B_ALUOP_LO] = 1'b1;
                uses_rs2        = 1'b1;
            end
            OPC_OP: begin
                dec[B_REGWRITE] = 1'b1;
                dec[B_ALUOP_HI] = 1'b1;
                uses_rs2        = 1'b1;
            end
            OPC_OPIMM: begin
                dec[B_REGWRITE] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
                dec[B_ALUOP_HI] = 1'b1;
                dec[B_ALUOP_LO] = 1'b1;
            end
            OPC_JAL: begin
                dec[B_JUMP]     = 1'b1;
                dec[B_REGWRITE] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
                uses_rs1        = 1'b0;
            end
            OPC_JALR: begin
                dec[B_JUMP]     = 1'b1;
                dec[B_REGWRITE] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
            end
            OPC_AUIPC: begin
                dec[B_AUIPC]    = 1'b1;
                dec[B_REGWRITE] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
                uses_rs1        = 1'b0;
            end
            OPC_LUI: begin
                dec[B_LUI]      = 1'b1;
                dec[B_REGWRITE] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
                uses_rs1        = 1'b0;
            end
            OPC_SYSTEM, OPC_FENCE: begin
                dec = '0;
            end
            default: begin
                dec[B_ILLEGAL]  = 1'b1;
            end
        endcase
    end

    // A load in EX whose destination feeds the entering instruction forces a bubble.
    assign rs1_hit  = uses_rs1 & (rs1 == rd_q[0]);
    assign rs2_hit  = uses_rs2 & (rs2 == rd_q[0]);
    assign load_use = in_valid & valid_q[0] & ctrl_q[0][B_MEMREAD] &
                      (rd_q[0] != '0) & (rs1_hit | rs2_hit);
    assign in_ready = ~stall & ~load_use & ~rst;
    assign bubble   = flush | load_use | ~in_valid;

    // Advance the control pipeline: reset clears, stall freezes, otherwise shift and load EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                rd_q[k]   <= '0;
            end
        end else if (!stall) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                ctrl_q[k]  <= ctrl_q[k-1];
                rd_q[k]    <= rd_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
            if (bubble) begin
                ctrl_q[0]  <= '0;
                rd_q[0]    <= '0;
                valid_q[0] <= 1'b0;
            end else begin
                ctrl_q[0]  <= dec;
                rd_q[0]    <= rd;
                valid_q[0] <= 1'b1;
            end
        end
    end

    // Flatten the per-stage registers onto the datapath tap buses.
    for (genvar g = 0; g < STAGES; g++) begin : g_taps
        assign ctrl_o[g*CW +: CW]     = ctrl_q[g];
        assign rd_o[g*RA_W +: RA_W]   = rd_q[g];
    end
    assign valid_o = valid_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: self-checking bench for ctrl_pipe. Two instances (3 and 5 stages)
// share the same stimulus; a stage-list reference model tracks both.
module tb_ctrl_pipe;

    localparam int CW   = 12;
    localparam int RA_W = 5;
    localparam int MS   = 5;

    logic clk = 1'b0;
    logic rst, in_valid, stall, flush;
    logic [4:0] opcode, rd, rs1, rs2;

    logic              in_ready3, load_use3, in_ready5, load_use5;
    logic [3*CW-1:0]   ctrl3;
    logic [2:0]        valid3;
    logic [3*RA_W-1:0] rd3;
    logic [5*CW-1:0]   ctrl5;
    logic [4:0]        valid5;
    logic [5*RA_W-1:0] rd5;

    int tests = 0;
    int fails = 0;
    logic lastLu, lastReady;

    // reference model: one record per stage, index 0 = EX
    logic [11:0] mCtrl  [MS];
    logic        mValid [MS];
    logic [4:0]  mRd    [MS];

    typedef struct {
        logic [4:0]  opc;
        logic [11:0] expCtrl;
        logic        expValid;
    } vec_t;
    vec_t tbl [32];

    // free-running clock
    always #5 clk = ~clk;

    ctrl_pipe #(.STAGES(3), .RA_W(RA_W)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .stall(stall), .flush(flush),
        .ctrl_o(ctrl3), .valid_o(valid3), .rd_o(rd3), .load_use(load_use3)
    );

    ctrl_pipe #(.STAGES(5), .RA_W(RA_W)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .stall(stall), .flush(flush),
        .ctrl_o(ctrl5), .valid_o(valid5), .rd_o(rd5), .load_use(load_use5)
    );

    // bundle assembled from named fields of the decode table
    function automatic logic [11:0] refBundle(input logic [4:0] op);
        logic ill, lui, auipc, jump, regw, alusrc, memw, m2r, memr, br;
        logic [1:0] aluop;
        {ill, lui, auipc, jump, regw, alusrc, memw, m2r, memr, br} = '0;
        aluop = 2'b00;
        case (op)
            5'b00000: begin memr = 1; m2r = 1; alusrc = 1; regw = 1; end
            5'b01000: begin memw = 1; alusrc = 1; end
            5'b11000: begin br = 1; aluop = 2'b01; end
            5'b01100: begin regw = 1; aluop = 2'b10; end
            5'b00100: begin regw = 1; alusrc = 1; aluop = 2'b11; end
            5'b11011, 5'b11001: begin jump = 1; regw = 1; alusrc = 1; end
            5'b00101: begin auipc = 1; regw = 1; alusrc = 1; end
            5'b01101: begin lui = 1; regw = 1; alusrc = 1; end
            5'b11100, 5'b00011: ;
            default: ill = 1;
        endcase
        return {ill, lui, auipc, jump, regw, alusrc, memw, aluop, m2r, memr, br};
    endfunction

    function automatic logic refLoadUse(input logic iv, input logic [4:0] op,
                                        input logic [4:0] s1, input logic [4:0] s2);
        logic u1, u2, isLoad;
        u1 = !(op inside {5'b01101, 5'b00101, 5'b11011});
        u2 = op inside {5'b01000, 5'b11000, 5'b01100};
        isLoad = mCtrl[0][1];
        return iv && mValid[0] && isLoad && (mRd[0] != 5'd0) &&
               ((u1 && s1 == mRd[0]) || (u2 && s2 == mRd[0]));
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < MS; k++) begin
            mCtrl[k] = '0; mValid[k] = 1'b0; mRd[k] = '0;
        end
    endtask

    // compare every registered tap of both instances against the model
    task automatic checkOutput();
        logic [5*CW-1:0]   eCtrl;
        logic [4:0]        eValid;
        logic [5*RA_W-1:0] eRd;
        for (int k = 0; k < MS; k++) begin
            eCtrl[k*CW +: CW]     = mCtrl[k];
            eValid[k]             = mValid[k];
            eRd[k*RA_W +: RA_W]   = mRd[k];
        end
        checkVal("ctrl3",  64'(ctrl3),  64'(eCtrl[3*CW-1:0]));
        checkVal("valid3", 64'(valid3), 64'(eValid[2:0]));
        checkVal("rd3",    64'(rd3),    64'(eRd[3*RA_W-1:0]));
        checkVal("ctrl5",  64'(ctrl5),  64'(eCtrl));
        checkVal("valid5", 64'(valid5), 64'(eValid));
        checkVal("rd5",    64'(rd5),    64'(eRd));
    endtask

    // drive one cycle of inputs, check combinational outputs, clock, check registers
    task automatic applyStimulus(input logic r, input logic iv, input logic [4:0] op,
                                 input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic st, input logic fl);
        logic eLu, eReady;
        rst = r; in_valid = iv; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        stall = st; flush = fl;
        #1;
        eLu    = refLoadUse(iv, op, s1, s2);
        eReady = !st && !eLu && !r;
        lastLu = load_use3;
        lastReady = in_ready3;
        checkVal("load_use3", 64'(load_use3), 64'(eLu));
        checkVal("load_use5", 64'(load_use5), 64'(eLu));
        checkVal("in_ready3", 64'(in_ready3), 64'(eReady));
        checkVal("in_ready5", 64'(in_ready5), 64'(eReady));
        @(posedge clk);
        if (r) begin
            clearModel();
        end else if (!st) begin
            for (int k = MS - 1; k >= 1; k--) begin
                mCtrl[k] = mCtrl[k-1]; mValid[k] = mValid[k-1]; mRd[k] = mRd[k-1];
            end
            if (fl || eLu || !iv) begin
                mCtrl[0] = '0; mValid[0] = 1'b0; mRd[0] = '0;
            end else begin
                mCtrl[0] = refBundle(op); mValid[0] = 1'b1; mRd[0] = d;
            end
        end
        #1;
        checkOutput();
    endtask

    initial begin
        // decode table: everything illegal unless listed
        for (int i = 0; i < 32; i++) begin
            tbl[i].opc = 5'(i);
            tbl[i].expCtrl = 12'h800;
            tbl[i].expValid = 1'b1;
        end
        tbl[5'b00000].expCtrl = 12'h0C6;
        tbl[5'b01000].expCtrl = 12'h060;
        tbl[5'b11000].expCtrl = 12'h009;
        tbl[5'b01100].expCtrl = 12'h090;
        tbl[5'b00100].expCtrl = 12'h0D8;
        tbl[5'b11011].expCtrl = 12'h1C0;
        tbl[5'b11001].expCtrl = 12'h1C0;
        tbl[5'b00101].expCtrl = 12'h2C0;
        tbl[5'b01101].expCtrl = 12'h4C0;
        tbl[5'b11100].expCtrl = 12'h000;
        tbl[5'b00011].expCtrl = 12'h000;

        // reset held two cycles with an OP presented
        rst = 1; in_valid = 1; opcode = 5'b01100; rd = 1; rs1 = 0; rs2 = 0;
        stall = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        clearModel();
        checkOutput();
        checkVal("reset valid3", 64'(valid3), 64'd0);
        checkVal("reset ctrl3", 64'(ctrl3), 64'd0);
        checkVal("reset in_ready", 64'(in_ready3), 64'd0);
        applyStimulus(0, 1, 5'b01100, 1, 0, 0, 0, 0);
        checkVal("post-reset valid0", 64'(valid3[0]), 64'd1);
        checkVal("post-reset ctrl0", 64'(ctrl3[11:0]), 64'h090);

        // decode sweep of all opcodes
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 1, tbl[i].opc, 1, 2, 2, 0, 0);
            checkVal($sformatf("decode op%0d", i), 64'(ctrl3[11:0]), 64'(tbl[i].expCtrl));
            checkVal($sformatf("decode valid op%0d", i), 64'(valid3[0]), 64'(tbl[i].expValid));
        end

        // propagation of a LOAD through every stage
        applyStimulus(0, 1, 5'b00000, 5, 1, 1, 0, 0);
        checkVal("prop s0 rd", 64'(rd3[4:0]), 64'd5);
        applyStimulus(0, 1, 5'b01100, 8, 6, 6, 0, 0);
        checkVal("prop s1 rd", 64'(rd3[9:5]), 64'd5);
        applyStimulus(0, 1, 5'b01100, 8, 6, 6, 0, 0);
        checkVal("prop s2 rd", 64'(rd3[14:10]), 64'd5);
        checkVal("prop s2 ctrl", 64'(ctrl3[35:24]), 64'h0C6);
        applyStimulus(0, 1, 5'b01100, 8, 6, 6, 0, 0);
        applyStimulus(0, 1, 5'b01100, 8, 6, 6, 0, 0);
        checkVal("prop5 s4 rd", 64'(rd5[24:20]), 64'd5);
        checkVal("prop5 s4 ctrl", 64'(ctrl5[59:48]), 64'h0C6);
        checkVal("prop5 valid", 64'(valid5), 64'h1F);

        // load-use hazard then retry
        applyStimulus(0, 1, 5'b00000, 7, 1, 1, 0, 0);
        applyStimulus(0, 1, 5'b01100, 9, 3, 7, 0, 0);
        checkVal("lu asserted", 64'(lastLu), 64'd1);
        checkVal("lu in_ready", 64'(lastReady), 64'd0);
        checkVal("lu bubble valid", 64'(valid3[0]), 64'd0);
        checkVal("lu bubble ctrl", 64'(ctrl3[11:0]), 64'd0);
        applyStimulus(0, 1, 5'b01100, 9, 3, 7, 0, 0);
        checkVal("lu retry rd", 64'(rd3[4:0]), 64'd9);
        checkVal("lu retry ctrl", 64'(ctrl3[11:0]), 64'h090);

        // load into x0 never stalls
        applyStimulus(0, 1, 5'b00000, 0, 1, 1, 0, 0);
        applyStimulus(0, 1, 5'b01100, 9, 0, 0, 0, 0);
        checkVal("x0 no hazard", 64'(lastLu), 64'd0);
        checkVal("x0 op valid", 64'(valid3[0]), 64'd1);

        // stall freezes all stages for three cycles
        applyStimulus(0, 1, 5'b01100, 10, 20, 20, 0, 0);
        applyStimulus(0, 1, 5'b01100, 11, 20, 20, 0, 0);
        applyStimulus(0, 1, 5'b01100, 12, 20, 20, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 5'b00000, 13, 20, 20, 1, 0);
            checkVal("stall rd3", 64'(rd3), 64'({5'd10, 5'd11, 5'd12}));
            checkVal("stall in_ready", 64'(lastReady), 64'd0);
        end
        applyStimulus(0, 1, 5'b00000, 13, 20, 20, 0, 0);
        checkVal("unstall s0 rd", 64'(rd3[4:0]), 64'd13);

        // flush kills the instruction behind a branch
        applyStimulus(0, 1, 5'b11000, 0, 1, 2, 0, 0);
        applyStimulus(0, 1, 5'b01100, 14, 1, 2, 0, 1);
        checkVal("flush bubble", 64'(valid3[0]), 64'd0);
        checkVal("flush bubble ctrl", 64'(ctrl3[11:0]), 64'd0);
        checkVal("flush branch s1", 64'(ctrl3[23:12]), 64'h009);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic r, iv, st, fl;
            logic [4:0] op;
            logic [4:0] ops [8];
            ops = '{5'b00000, 5'b00000, 5'b01000, 5'b11000, 5'b01100,
                    5'b00100, 5'b11011, 5'b01101};
            r  = ($urandom_range(0, 49) == 0);
            st = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ops[$urandom_range(0, 7)];
            applyStimulus(r, iv, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), st, fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
